mul_arbiter: RTL and testbench
==============================

# mul_arbiter

Round-robin arbiter and scheduler sharing one registered 32x32 Wallace-tree multiplier (registered_WTM, fixed 2-cycle latency) between NREQ independent requesters. Accepts one operand pair per cycle via valid/ready handshakes, drives the multiplier operand inputs, and tracks each in-flight product with a tag pipeline. Returns every 64-bit result to the requester that issued it. Sits between the requester cluster and the single shared multiplier instance.

## Interface
- NREQ, 4: number of requesters, 2..8.
- LATENCY, 2: cycles from operands driven on mul_a/mul_b to the product on mul_result; must match the multiplier.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; also drives the multiplier's reset.
- enable  in  1  1 = grants allowed; 0 = no new grants, in-flight ops drain.
- req_valid  in  NREQ  requester i has an operand pair.
- req_ready  out  NREQ  one-hot or zero; grant to requester i this cycle.
- req_a  in  NREQ*32  operand A, requester i at bits [32i+31:32i].
- req_b  in  NREQ*32  operand B, same packing.
- mul_a  out  32  operand A to the multiplier.
- mul_b  out  32  operand B to the multiplier.
- mul_result  in  64  product from the multiplier.
- resp_valid  out  NREQ  one-hot or zero; result for requester i is valid this cycle.
- resp_result  out  64  product, valid when any resp_valid bit is set.
- idle  out  1  1 when no operation is in flight.
- op_count  out  32  number of accepted operations, wraps at 2^32.

## Operation
- Grant: when enable=1, pick the first i with req_valid[i]=1, searching from rr_ptr upward modulo NREQ. Set req_ready[i]=1. This is combinational from req_valid, enable and rr_ptr.
- Transfer: occurs when req_valid[i] & req_ready[i]. At most one transfer per cycle.
- Pointer update: after a transfer by requester i, rr_ptr <= (i+1) mod NREQ. With no transfer, rr_ptr holds.
- Operand mux: mul_a/mul_b = req_a/req_b slice of the granted requester. With no grant, both are 0.
- Tag pipeline: LATENCY stages, each holding {vld, id[$clog2(NREQ)-1:0]}. Stage 0 loads {transfer, granted id} every cycle. Stages shift every cycle, with no stall.
- Response: last stage vld=1 -> resp_valid[id]=1 and resp_result=mul_result. Otherwise resp_valid=0 and resp_result=0.
- No response backpressure: requesters must accept resp_valid on the cycle it is asserted.
- idle = 1 when no tag stage has vld set.
- op_count increments by 1 per transfer.
- Multiplication is unsigned, 32x32 -> 64, with no truncation.

## Timing
- Reset values: rr_ptr=0, all tag stages invalid, op_count=0, resp_valid=0, resp_result=0, idle=1. req_ready and mul_a/mul_b follow the combinational rules above (0 if no req_valid).
- Latency: a transfer in cycle t produces resp_valid in cycle t+LATENCY. Throughput is 1 op/cycle.
- Sustained contention: all NREQ requesters valid -> grants rotate 0,1,..,NREQ-1,0,...
- A single requester holding valid is granted every cycle.
- enable drops with ops in flight: no new grants; in-flight results still return; idle rises after the last one.
- Requester deasserts valid before being granted: no penalty; rr_ptr unchanged.
- Reset mid-operation: all in-flight tags are discarded, and no resp_valid is produced for them, even though the multiplier is also reset.
- op_count wraps from 0xFFFFFFFF to 0.

## Structure
- Package mul_arb_pkg: OPW=32, RESW=64, default NREQ/LATENCY, and the tag struct/typedef {vld, id}.
- Sub-module rr_arbiter: NREQ-wide round-robin grant with pointer input and one-hot output. It is reusable.
- mul_arbiter holds rr_ptr, the tag pipeline, op_count, and the operand and response muxing. The multiplier is instantiated at the level above.

## Test plan
- Reset, then requester 2 sends A=7, B=6 -> req_ready[2] the same cycle; resp_valid=0100, resp_result=42 two cycles later; op_count=1.
- All 4 requesters valid for 8 cycles with A=i+1, B=0xFFFFFFFF -> grant order 0,1,2,3,0,1,2,3; each response id matches, result = (i+1)*0xFFFFFFFF.
- A=B=0xFFFFFFFF -> resp_result=0xFFFFFFFE00000001.
- 3 ops in flight, then enable=0 -> no further req_ready; the 3 responses arrive; idle=1 on the following cycle.
- Reset asserted 1 cycle after a transfer -> no resp_valid ever for it; op_count=0; rr_ptr=0 (next grant to the lowest valid index).
- op_count preset near wrap via 2^32 back-to-back transfers (or forced) -> reads 0 after 0xFFFFFFFF.

Source files
------------

// File: rtl/mul_arbiter_pkg.sv
// Shared constants and the in-flight tag type for the multiplier arbiter.
package mul_arb_pkg;

  localparam int OPW         = 32;  // operand width
  localparam int RESW        = 64;  // full unsigned product width
  localparam int NREQ_DEF    = 4;
  localparam int LATENCY_DEF = 2;
  localparam int IDW         = 3;   // id field wide enough for up to 8 requesters

  // One tag pipeline stage: marks a product in flight and who issued it.
  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/mul_arbiter_if.sv
// Requester-side bus: operand handshakes in, per-requester results out.
interface mul_arb_if
  import mul_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_a;
  logic [NREQ*OPW-1:0] req_b;
  logic [NREQ-1:0]     resp_valid;
  logic [RESW-1:0]     resp_result;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, resp_valid, resp_result
  );

endinterface

// File: rtl/mul_arbiter_rr_arbiter.sv
// Reusable round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_id_o,
  output logic          gnt_vld_o
);

  int idx;

  // Scan N positions starting at the pointer; the first valid one is granted.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    gnt_o     = '0;
    gnt_id_o  = '0;
    gnt_vld_o = 1'b0;
    idx       = 0;
    if (en_i) begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr_i) + k) % N;
        if (!gnt_vld_o && req_i[idx]) begin
          gnt_o[idx] = 1'b1;
          gnt_id_o   = PW'(idx);
          gnt_vld_o  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one fixed-latency multiplier between NREQ requesters and routes
// each product back to its issuer using a tag pipeline that mirrors the
// multiplier's latency.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable_i,
  mul_arb_if.slave        bus,
  output logic [OPW-1:0]  mul_a_o,
  output logic [OPW-1:0]  mul_b_o,
  input  logic [RESW-1:0] mul_result_i,
  output logic            idle_o,
  output logic [31:0]     op_count_o
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_id;
  logic            gnt_vld;
  logic [31:0]     op_count_q, op_count_d;
  tag_t            tag_d;
  tag_t            tag_q [LATENCY];
  tag_t            tag_last;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req_i     (bus.req_valid),
    .en_i      (enable_i),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_id_o  (gnt_id),
    .gnt_vld_o (gnt_vld)
  );

  // A grant always goes to a valid requester, so a grant is a transfer.
  assign bus.req_ready = gnt;
  assign op_count_o    = op_count_q;
  assign tag_last      = tag_q[LATENCY-1];

  // Next state: pointer moves past the winner, count bumps, new tag enters.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    if (gnt_vld) begin
      rr_ptr_d = (gnt_id == PW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end
    op_count_d = op_count_q + 32'(gnt_vld);
    tag_d      = '{vld: gnt_vld, id: IDW'(gnt_id)};
  end

  // State registers: pointer, operation counter and the tag shift pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      op_count_q <= '0;
      // NOTE: the tag array is reset because its vld bits decide whether a
      // response fires; a stale vld after reset would return a bogus result.
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage shifts from the old values.
      rr_ptr_q   <= rr_ptr_d;
      op_count_q <= op_count_d;
      tag_q[0]   <= tag_d;
      for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Operand mux: forward the granted requester's pair, zeros when idle.
  always_comb begin
    mul_a_o = '0;
    mul_b_o = '0;
    if (gnt_vld) begin
      mul_a_o = bus.req_a[int'(gnt_id)*OPW +: OPW];
      mul_b_o = bus.req_b[int'(gnt_id)*OPW +: OPW];
    end
  end

  // Response steering from the oldest tag, plus the in-flight idle flag.
  always_comb begin
    bus.resp_valid  = '0;
    bus.resp_result = '0;
    if (tag_last.vld) begin
      bus.resp_valid  = NREQ'(1) << tag_last.id;
      bus.resp_result = mul_result_i;
    end
    idle_o = 1'b1;
    for (int i = 0; i < LATENCY; i++) begin
      if (tag_q[i].vld) idle_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: directed vectors push expected responses into a
// scoreboard; a monitor pops and compares whenever a response appears.
module tb_mul_arbiter;
  import mul_arb_pkg::*;

  localparam int N = 4;

  typedef struct {
    int          id;
    logic [63:0] res;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [31:0] mul_a, mul_b, op_count;
  logic [63:0] mul_result, p1, p2;
  logic        idle;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        sb [$];

  localparam logic [63:0] T2_RES [4] = '{
    64'h0000_0000_FFFF_FFFF, 64'h0000_0001_FFFF_FFFE,
    64'h0000_0002_FFFF_FFFD, 64'h0000_0003_FFFF_FFFC
  };

  mul_arb_if #(.NREQ(N)) bus ();

  mul_arbiter #(.NREQ(N), .LATENCY(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable_i     (enable),
    .bus          (bus),
    .mul_a_o      (mul_a),
    .mul_b_o      (mul_b),
    .mul_result_i (mul_result),
    .idle_o       (idle),
    .op_count_o   (op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Two-stage registered unsigned multiplier, reset together with the arbiter.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      p1 <= '0;
      p2 <= '0;
    end else begin
      p1 <= 64'(mul_a) * 64'(mul_b);
      p2 <= p1;
    end
  end
  assign mul_result = p2;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[i*32 +: 32] = a;
    bus.req_b[i*32 +: 32] = b;
  endtask

  // One cycle: check grant (and optionally idle) mid-cycle, queue the result.
  task automatic step(input string nm, input logic [N-1:0] exp_rdy,
                      input logic [63:0] exp_res, input bit push, input int exp_idle);
    @(negedge clk);
    check({nm, "_rdy"}, 64'(bus.req_ready), 64'(exp_rdy));
    if (exp_idle >= 0) check({nm, "_idle"}, 64'(idle), 64'(exp_idle));
    if (push && exp_rdy != '0) sb.push_back('{onehot_idx(exp_rdy), exp_res, cyc + 2});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Monitor: every presented response must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.resp_valid != '0) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", 64'(bus.resp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("resp_cyc", 64'(cyc), 64'(e.cyc));
        check("resp_valid", 64'(bus.resp_valid), 64'(1) << e.id);
        check("resp_result", bus.resp_result, e.res);
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      check("resp_missing", 64'(bus.resp_valid), 64'(1) << sb[0].id);
      void'(sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] exp_r;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    enable        = 1'b1;
    reset         = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_opcnt", 64'(op_count), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_result", bus.resp_result, 64'd0);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single requester 2: 7*6
    set_op(2, 32'd7, 32'd6);
    bus.req_valid = 4'b0100;
    step("t1", 4'b0100, 64'd42, 1, 1);
    bus.req_valid = '0;
    step("t1_w0", '0, '0, 0, 0);
    step("t1_w1", '0, '0, 0, 0);
    step("t1_w2", '0, '0, 0, 1);
    check("t1_opcnt", 64'(op_count), 64'd1);

    // Full contention from a fresh pointer: rotation 0,1,2,3,...
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 32'(i + 1), 32'hFFFF_FFFF);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_r = '0;
      exp_r[k % 4] = 1'b1;
      step($sformatf("t2_%0d", k), exp_r, T2_RES[k % 4], 1, -1);
    end

    // Single requester held valid, max operands
    set_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bus.req_valid = 4'b0010;
    for (int k = 0; k < 3; k++)
      step($sformatf("t3_%0d", k), 4'b0010, 64'hFFFF_FFFE_0000_0001, 1, -1);

    // Three ops in flight then enable drops (pointer is at 2)
    set_op(0, 32'd10, 32'd100);
    set_op(1, 32'd11, 32'd101);
    set_op(3, 32'd13, 32'd103);
    bus.req_valid = 4'b1011;
    step("t4_g0", 4'b1000, 64'd1339, 1, 0);
    step("t4_g1", 4'b0001, 64'd1000, 1, 0);
    step("t4_g2", 4'b0010, 64'd1111, 1, 0);
    enable = 1'b0;
    step("t4_d0", '0, '0, 0, 0);
    step("t4_d1", '0, '0, 0, 0);
    step("t4_d2", '0, '0, 0, 1);
    step("t4_d3", '0, '0, 0, 1);
    check("t4_opcnt", 64'(op_count), 64'd14);

    // Reset one cycle after a transfer: its result must never appear
    enable = 1'b1;
    set_op(0, 32'd5, 32'd5);
    bus.req_valid = 4'b0001;
    step("t5_g", 4'b0001, 64'd25, 0, 1);
    bus.req_valid = '0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    step("t5_w0", '0, '0, 0, 1);
    step("t5_w1", '0, '0, 0, 1);
    check("t5_opcnt", 64'(op_count), 64'd0);
    set_op(0, 32'd3, 32'd4);
    bus.req_valid = 4'b1001;
    step("t5_ptr", 4'b0001, 64'd12, 1, 1);

    // Requester drops valid before being granted: pointer stays at 1
    enable = 1'b0;
    bus.req_valid = 4'b0100;
    step("t6_hold", '0, '0, 0, -1);
    bus.req_valid = '0;
    step("t6_drop", '0, '0, 0, -1);
    enable = 1'b1;
    set_op(1, 32'd9, 32'd9);
    bus.req_valid = 4'b0011;
    step("t6_ptr", 4'b0010, 64'd81, 1, -1);

    // op_count wrap
    bus.req_valid = '0;
    force dut.op_count_q = 32'hFFFF_FFFF;
    step("t7_f", '0, '0, 0, -1);
    check("t7_opcnt_max", 64'(op_count), 64'hFFFF_FFFF);
    release dut.op_count_q;
    set_op(0, 32'd2, 32'd3);
    bus.req_valid = 4'b0001;
    step("t7_g", 4'b0001, 64'd6, 1, -1);
    check("t7_opcnt_wrap", 64'(op_count), 64'd0);

    // Drain
    bus.req_valid = '0;
    step("drain0", '0, '0, 0, -1);
    step("drain1", '0, '0, 0, -1);
    step("drain2", '0, '0, 0, 1);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
